// File: rtl/mult_arbiter.sv
// Two-requester front end for a shared multi-cycle multiplier.
// Requests are arbitrated round-robin in IDLE. The winner's operands are latched
// and driven to the multiplier, and the result is returned as a one-cycle strobe.
// A bounded wait turns a hung multiplier into an error response plus a clear pulse.
module mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] opa0,
    input  logic [WIDTH-1:0] opb0,
    input  logic [WIDTH-1:0] opa1,
    input  logic [WIDTH-1:0] opb1,
    output logic [1:0]       ack,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_start,
    output logic             mul_clr,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4,
        ABORT = 3'd5
    } state_t;

    // The counter holds the number of completed WAIT cycles, so the TIMEOUT-th
    // WAIT cycle is the one on which the counter reads TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic             id_reg;
    logic             last_reg;
    logic [7:0]       cnt_reg;
    logic [WIDTH-1:0] mul_a_reg, mul_b_reg;
    logic [WIDTH-1:0] rsp_data_reg;

    logic             grant;
    logic             winner;
    logic             load_rsp;
    logic             zero_rsp;
    logic             cnt_clr;
    logic             cnt_inc;

    assign mul_a    = mul_a_reg;
    assign mul_b    = mul_b_reg;
    assign rsp_data = rsp_data_reg;

    // Round-robin pick: a lone request wins outright; on a tie, the requester not served last wins.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_reg;
        end else begin
            winner = req[1];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic, plus one-cycle strobes decoded from the current state.
    always_comb begin
        state_next = state_reg;
        ack        = 2'b00;
        rsp_valid  = 2'b00;
        rsp_err    = 1'b0;
        mul_start  = 1'b0;
        mul_clr    = 1'b0;
        busy       = 1'b1;
        grant      = 1'b0;
        load_rsp   = 1'b0;
        zero_rsp   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    grant      = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                ack[id_reg] = 1'b1;
                state_next  = START;
            end
            START: begin
                mul_start  = 1'b1;
                cnt_clr    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                cnt_inc = 1'b1;
                // Completion on the final allowed cycle still counts as success.
                if (mul_done) begin
                    load_rsp   = 1'b1;
                    state_next = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    zero_rsp   = 1'b1;
                    state_next = ABORT;
                end
            end
            RESP: begin
                rsp_valid[id_reg] = 1'b1;
                state_next        = IDLE;
            end
            ABORT: begin
                mul_clr           = 1'b1;
                rsp_valid[id_reg] = 1'b1;
                rsp_err           = 1'b1;
                state_next        = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: grant capture, timeout counter, and response data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_reg       <= 1'b0;
            last_reg     <= 1'b1;
            cnt_reg      <= 8'd0;
            mul_a_reg    <= '0;
            mul_b_reg    <= '0;
            rsp_data_reg <= '0;
        end else begin
            if (grant) begin
                id_reg    <= winner;
                last_reg  <= winner;
                mul_a_reg <= winner ? opa1 : opa0;
                mul_b_reg <= winner ? opb1 : opb0;
            end
            if (cnt_clr) begin
                cnt_reg <= 8'd0;
            end else if (cnt_inc && (cnt_reg != 8'hff)) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
            if (load_rsp) begin
                rsp_data_reg <= mul_out;
            end else if (zero_rsp) begin
                rsp_data_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter.
// It includes a multiplier stub that returns the upper half of the product.
// The stub has a programmable latency: latency n raises done on WAIT cycle n+1.
// A hang mode keeps done low so the timeout path can be exercised.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] opa0 = '0, opb0 = '0, opa1 = '0, opb1 = '0;
    logic [1:0]  ack, rsp_valid;
    logic [15:0] rsp_data, mul_a, mul_b, mul_out;
    logic        rsp_err, busy, mul_start, mul_clr, mul_done;

    int compared   = 0;
    int mismatched = 0;

    // stub controls
    int          stub_lat  = 5;
    bit          stub_hang = 1'b0;
    logic [7:0]  stub_cnt;
    logic        stub_done;
    logic [15:0] stub_out;
    logic [31:0] prod;

    assign prod     = mul_a * mul_b;
    assign mul_done = stub_done;
    assign mul_out  = stub_out;

    mult_arbiter #(.WIDTH(16), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req),
        .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_clr(mul_clr), .mul_done(mul_done), .mul_out(mul_out)
    );

    always #5 clk = ~clk;

    // multiplier stub: done is a level held until the next start
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_cnt  <= 8'd0;
            stub_done <= 1'b0;
            stub_out  <= '0;
        end else if (mul_start) begin
            stub_out  <= prod[31:16];
            stub_cnt  <= stub_hang ? 8'd0 : 8'(stub_lat);
            stub_done <= (!stub_hang && stub_lat == 0);
        end else if (stub_cnt != 8'd0) begin
            stub_cnt <= stub_cnt - 8'd1;
            if (stub_cnt == 8'd1) stub_done <= 1'b1;
        end
    end

    // waits (bounded) at negedges until a response strobe; n = negedges advanced, -1 on timeout
    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid == 2'b00) n = -1;
        $display("txn: rsp after %0d cycles valid=%b data=%h err=%b", n, rsp_valid, rsp_data, rsp_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if ({ack, rsp_valid, rsp_err, busy, mul_start, mul_clr} !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {ack, rsp_valid, rsp_err, busy, mul_start, mul_clr});
        end
        compared++;
        if ({mul_a, mul_b, rsp_data} !== 48'h0) begin
            mismatched++;
            $display("FAIL reset_data: got %h expected 0", {mul_a, mul_b, rsp_data});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        $display("txn: reset released");
    endtask

    task automatic test_single();
        int n;
        stub_lat = 5; stub_hang = 1'b0;
        @(negedge clk);
        req = 2'b01; opa0 = 16'h2000; opb0 = 16'h2000;
        @(negedge clk);
        compared++;
        if (ack !== 2'b01) begin mismatched++; $display("FAIL single_ack: got %b expected 01", ack); end
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL single_busy: got %b expected 1", busy); end
        compared++;
        if (mul_a !== 16'h2000 || mul_b !== 16'h2000) begin
            mismatched++; $display("FAIL single_ops: got %h/%h expected 2000/2000", mul_a, mul_b);
        end
        req = 2'b00;
        @(negedge clk);
        compared++;
        if (ack !== 2'b00 || mul_start !== 1'b1) begin
            mismatched++; $display("FAIL single_start: got ack=%b start=%b expected ack=00 start=1", ack, mul_start);
        end
        wait_rsp(n);
        compared++;
        if (n !== 7) begin mismatched++; $display("FAIL single_latency: got %0d expected 7", n); end
        compared++;
        if (rsp_valid !== 2'b01 || rsp_data !== 16'h0400 || rsp_err !== 1'b0) begin
            mismatched++;
            $display("FAIL single_rsp: got v=%b d=%h e=%b expected v=01 d=0400 e=0", rsp_valid, rsp_data, rsp_err);
        end
        @(negedge clk);
        compared++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 16'h0400) begin
            mismatched++;
            $display("FAIL single_after: got v=%b busy=%b d=%h expected v=00 busy=0 d=0400", rsp_valid, busy, rsp_data);
        end
    endtask

    task automatic test_min_latency();
        int n;
        stub_lat = 0; stub_hang = 1'b0;
        req = 2'b10; opa1 = 16'h0100; opb1 = 16'h0300;
        @(negedge clk);
        compared++;
        if (ack !== 2'b10) begin mismatched++; $display("FAIL minlat_ack: got %b expected 10", ack); end
        req = 2'b00;
        wait_rsp(n);
        compared++;
        if (n !== 3) begin mismatched++; $display("FAIL minlat_latency: got %0d expected 3", n); end
        compared++;
        if (rsp_valid !== 2'b10 || rsp_data !== 16'h0003) begin
            mismatched++; $display("FAIL minlat_rsp: got v=%b d=%h expected v=10 d=0003", rsp_valid, rsp_data);
        end
        // done stays high in IDLE and must be ignored there
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_data !== 16'h0003) begin
            mismatched++; $display("FAIL minlat_idle_done: got busy=%b v=%b d=%h expected 0/00/0003", busy, rsp_valid, rsp_data);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        stub_lat = 5; stub_hang = 1'b0;
        do_reset();
        req = 2'b11;
        opa0 = 16'h8000; opb0 = 16'h8000; opa1 = 16'h0d00; opb1 = 16'h0600;
        @(negedge clk);
        compared++;
        if (ack !== 2'b01 || mul_a !== 16'h8000) begin
            mismatched++; $display("FAIL simul_first_ack: got ack=%b a=%h expected 01/8000", ack, mul_a);
        end
        req = 2'b10;
        wait_rsp(n);
        compared++;
        if (rsp_valid !== 2'b01 || rsp_data !== 16'h4000) begin
            mismatched++; $display("FAIL simul_rsp0: got v=%b d=%h expected 01/4000", rsp_valid, rsp_data);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || ack !== 2'b00) begin
            mismatched++; $display("FAIL simul_gap: got busy=%b ack=%b expected 0/00", busy, ack);
        end
        @(negedge clk);
        compared++;
        if (ack !== 2'b10 || mul_a !== 16'h0d00 || mul_b !== 16'h0600) begin
            mismatched++; $display("FAIL simul_second_ack: got ack=%b a=%h b=%h expected 10/0d00/0600", ack, mul_a, mul_b);
        end
        req = 2'b00;
        wait_rsp(n);
        compared++;
        if (rsp_valid !== 2'b10 || rsp_data !== 16'h004e) begin
            mismatched++; $display("FAIL simul_rsp1: got v=%b d=%h expected 10/004e", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_fairness();
        int n;
        stub_lat = 2; stub_hang = 1'b0;
        opa0 = 16'h0300; opb0 = 16'h0500; opa1 = 16'h0700; opb1 = 16'h0200;
        @(negedge clk);
        req = 2'b11;
        @(negedge clk);
        compared++;
        if (ack !== 2'b01) begin mismatched++; $display("FAIL fair_first: got %b expected 01", ack); end
        wait_rsp(n);
        compared++;
        if (rsp_valid !== 2'b01 || rsp_data !== 16'h000f) begin
            mismatched++; $display("FAIL fair_rsp0: got v=%b d=%h expected 01/000f", rsp_valid, rsp_data);
        end
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (ack !== 2'b10) begin mismatched++; $display("FAIL fair_second: got %b expected 10", ack); end
        req = 2'b01;
        wait_rsp(n);
        compared++;
        if (rsp_valid !== 2'b10 || rsp_data !== 16'h000e) begin
            mismatched++; $display("FAIL fair_rsp1: got v=%b d=%h expected 10/000e", rsp_valid, rsp_data);
        end
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (ack !== 2'b01) begin mismatched++; $display("FAIL fair_third: got %b expected 01", ack); end
        req = 2'b00;
        wait_rsp(n);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        stub_hang = 1'b1;
        req = 2'b01; opa0 = 16'h1000; opb0 = 16'h1000;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        compared++;
        if (mul_start !== 1'b1) begin mismatched++; $display("FAIL tmo_start: got %b expected 1", mul_start); end
        wait_rsp(n);
        compared++;
        if (n !== 65) begin mismatched++; $display("FAIL tmo_cycles: got %0d expected 65", n); end
        compared++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 16'h0000 || mul_clr !== 1'b1) begin
            mismatched++;
            $display("FAIL tmo_rsp: got v=%b e=%b d=%h clr=%b expected 01/1/0000/1", rsp_valid, rsp_err, rsp_data, mul_clr);
        end
        @(negedge clk);
        compared++;
        if (mul_clr !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL tmo_after: got clr=%b e=%b busy=%b expected 0/0/0", mul_clr, rsp_err, busy);
        end
        stub_hang = 1'b0;
    endtask

    task automatic test_done_boundary();
        int n;
        // done one cycle too late: still a timeout
        stub_lat = 64;
        req = 2'b10; opa1 = 16'h0400; opb1 = 16'h0400;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        wait_rsp(n);
        compared++;
        if (n !== 65 || rsp_valid !== 2'b10 || rsp_err !== 1'b1) begin
            mismatched++; $display("FAIL late_done: got n=%0d v=%b e=%b expected 65/10/1", n, rsp_valid, rsp_err);
        end
        @(negedge clk);
        // done exactly on the 64th WAIT cycle: normal completion
        stub_lat = 63;
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        wait_rsp(n);
        compared++;
        if (n !== 65 || rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_data !== 16'h0010 || mul_clr !== 1'b0) begin
            mismatched++;
            $display("FAIL edge_done: got n=%0d v=%b e=%b d=%h clr=%b expected 65/10/0/0010/0", n, rsp_valid, rsp_err, rsp_data, mul_clr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int n;
        stub_lat = 5;
        req = 2'b01; opa0 = 16'h1234; opb0 = 16'h5678;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({ack, rsp_valid, rsp_err, busy, mul_start, mul_clr} !== 8'h00 || {mul_a, mul_b, rsp_data} !== 48'h0) begin
            mismatched++;
            $display("FAIL midrst_outputs: got ctrl=%b data=%h expected all zero",
                     {ack, rsp_valid, rsp_err, busy, mul_start, mul_clr}, {mul_a, mul_b, rsp_data});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (rsp_valid !== 2'b00 || mul_clr !== 1'b0) begin
                mismatched++; $display("FAIL midrst_quiet: got v=%b clr=%b expected 00/0", rsp_valid, mul_clr);
            end
        end
        rst = 1'b1;
        req = 2'b10; opa1 = 16'h0b00; opb1 = 16'h0070;
        @(negedge clk);
        compared++;
        if (ack !== 2'b10) begin mismatched++; $display("FAIL midrst_ack: got %b expected 10", ack); end
        req = 2'b00;
        wait_rsp(n);
        compared++;
        if (rsp_valid !== 2'b10 || rsp_data !== 16'h0004 || rsp_err !== 1'b0) begin
            mismatched++; $display("FAIL midrst_rsp: got v=%b d=%h e=%b expected 10/0004/0", rsp_valid, rsp_data, rsp_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_min_latency();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_done_boundary();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
